channel_stream_tx: RTL and testbench
====================================

CHANNEL_STREAM_TX -- requirements
Module: channel_stream_tx

Interface
REQ-001 SHALL have parameter C_M_AXIS_TDATA_WIDTH, default 32, stream data width; only 32 is supported.
REQ-002 SHALL have parameter SAMPLING_RATE, default 500, frames per block for block_flag.
REQ-003 SHALL have port m_axis_aclk  input  1  sole clock; all logic on rising edge.
REQ-004 SHALL have port m_axis_aresetn  input  1  reset, synchronous, active-low.
REQ-005 SHALL have port sample_valid  input  1  one-cycle strobe; ch1..ch4 hold a new 4-channel sample.
REQ-006 SHALL have ports ch1_data, ch2_data, ch3_data, ch4_data  input  16 each  channel samples.
REQ-007 SHALL have port m_axis_tvalid  output  1  AXI-Stream master valid.
REQ-008 SHALL have port m_axis_tready  input  1  AXI-Stream slave ready.
REQ-009 SHALL have port m_axis_tdata  output  32  stream payload.
REQ-010 SHALL have port m_axis_tlast  output  1  marks second beat of a frame.
REQ-011 SHALL have port overflow  output  1  sticky; a sample was dropped.
REQ-012 SHALL have port drop_count  output  16  number of dropped samples, saturating at 16'hFFFF.
REQ-013 SHALL have port block_flag  output  1  one-cycle pulse per SAMPLING_RATE frames sent.

Function
REQ-014 Frame = 2 beats: beat0 tdata = {ch2_data, ch1_data}, tlast=0; beat1 tdata = {ch4_data, ch3_data}, tlast=1.
REQ-015 Samples buffered in a 2-frame (64-bit entry) FIFO; capture on sample_valid when FIFO not full.
REQ-016 Full test uses occupancy after same-cycle pop: sample_valid coinciding with the beat1 handshake of a full FIFO SHALL be accepted.
REQ-017 sample_valid while full (no same-cycle pop) SHALL drop the sample, set overflow, increment drop_count (saturating); FIFO contents unchanged.
REQ-018 State machine IDLE, BEAT0, BEAT1; m_axis_tvalid = (state != IDLE), registered.
REQ-019 IDLE -> BEAT0 when FIFO non-empty or a capture occurs this cycle; first beat0 valid the cycle after sample_valid (latency 1).
REQ-020 BEAT0 -> BEAT1 on handshake (tvalid & tready); otherwise hold.
REQ-021 BEAT1 on handshake pops FIFO head; -> BEAT0 if entries remain (counting same-cycle capture), else IDLE.
REQ-022 While tvalid=1 and tready=0, tdata and tlast SHALL remain stable; tvalid never deasserts without handshake.
REQ-023 tdata/tlast are taken from the FIFO head only; data not zeroed in IDLE (last value held).
REQ-024 Back-to-back frames SHALL stream at one beat per cycle with tready held high (no bubble between frames).
REQ-025 Frame counter (32-bit) increments on each beat1 handshake; when it reaches SAMPLING_RATE, block_flag pulses for exactly the next cycle and counter returns to 0.
REQ-026 overflow clears only on reset; drop_count never wraps.

Reset
REQ-027 While m_axis_aresetn=0 at a clock edge: state IDLE, FIFO empty, frame counter 0.
REQ-028 Reset values: m_axis_tvalid 0, m_axis_tlast 0, m_axis_tdata 0, overflow 0, drop_count 0, block_flag 0.
REQ-029 Reset mid-frame SHALL discard the in-flight and buffered frames; tvalid low the cycle after the reset edge; sample_valid during reset ignored.
REQ-030 First capture after reset release follows REQ-019 with no extra latency.

Verification
REQ-031 Single sample ch1..ch4 = 1111,2222,3333,4444 hex, tready=1 -> beat0 22221111 tlast0 at +1, beat1 44443333 tlast1 at +2, then tvalid 0.
REQ-032 tready=0 for 5 cycles during beat0 -> tdata/tlast stable all 5 cycles; beat1 follows release; no data lost.
REQ-033 tready=0, 3 samples strobed -> first 2 buffered, third dropped; overflow=1, drop_count=1; release ready -> exactly 2 frames in order.
REQ-034 FIFO full, sample_valid on beat1 handshake cycle -> sample accepted, drop_count unchanged, 3 frames total emitted.
REQ-035 SAMPLING_RATE=4, 9 frames with tready=1 -> block_flag pulses twice, each 1 cycle, after 4th and 8th beat1 handshakes.
REQ-036 Reset asserted during beat1 with 1 frame queued -> tvalid 0, overflow 0, drop_count 0 after reset; next sample emitted normally.

Source files
------------

// File: rtl/channel_stream_tx.sv
`default_nettype none
// ============================================================================
// Module      : channel_stream_tx
// Description : Packs 4 x 16-bit channel samples into 2-beat AXI-Stream
//               frames. Samples are held in a 2-entry FIFO. A sample that
//               arrives while the FIFO is full is dropped and counted. A
//               one-cycle block_flag pulse is generated every SAMPLING_RATE
//               frames that are sent.
// Ports       : m_axis_aclk / m_axis_aresetn - clock, sync active-low reset
//               sample_valid, ch1..ch4_data  - sample strobe and channel data
//               m_axis_tvalid/tready/tdata/tlast - AXI-Stream master
//               overflow, drop_count          - sticky drop flag, drop count
//               block_flag                    - pulse every SAMPLING_RATE frames
// Revision    : 1.0 - initial release
// ============================================================================
module channel_stream_tx #(
    parameter int C_M_AXIS_TDATA_WIDTH = 32,
    parameter int SAMPLING_RATE        = 500
) (
    input  logic                            m_axis_aclk,
    input  logic                            m_axis_aresetn,
    input  logic                            sample_valid,
    input  logic [15:0]                     ch1_data,
    input  logic [15:0]                     ch2_data,
    input  logic [15:0]                     ch3_data,
    input  logic [15:0]                     ch4_data,
    output logic                            m_axis_tvalid,
    input  logic                            m_axis_tready,
    output logic [C_M_AXIS_TDATA_WIDTH-1:0] m_axis_tdata,
    output logic                            m_axis_tlast,
    output logic                            overflow,
    output logic [15:0]                     drop_count,
    output logic                            block_flag
);

    localparam logic [31:0] C_RATE = 32'(SAMPLING_RATE);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        BEAT0 = 2'd1,
        BEAT1 = 2'd2
    } state_t;

    state_t      r_state;
    state_t      w_state_next;

    logic [63:0] r_mem [2];
    logic        r_rd_ptr;
    logic        r_wr_ptr;
    logic [1:0]  r_count;
    logic [31:0] r_frame_cnt;

    logic        w_pop;
    logic        w_full_after_pop;
    logic        w_capture;
    logic        w_drop;
    logic [1:0]  w_left_after_pop;
    logic [1:0]  w_count_next;
    logic [63:0] w_sample;
    logic [63:0] w_head;
    logic [31:0] w_frame_inc;

    assign w_sample = {ch4_data, ch3_data, ch2_data, ch1_data};

    // The beat1 handshake frees a slot in the same cycle, so the full test
    // looks at occupancy after that pop.
    assign w_pop            = (r_state == BEAT1) && m_axis_tready;
    assign w_left_after_pop = r_count - {1'b0, w_pop};
    assign w_full_after_pop = (w_left_after_pop == 2'd2);
    assign w_capture        = sample_valid && !w_full_after_pop;
    assign w_drop           = sample_valid && w_full_after_pop;
    assign w_count_next     = w_left_after_pop + {1'b0, w_capture};
    assign w_frame_inc      = r_frame_cnt + 32'd1;

    // Head entry as it will be after this cycle's pop/push. When the FIFO
    // drains to empty by the pop, the only possible head is the sample
    // being captured right now (bypass for latency-1 start).
    always_comb begin
        w_head = r_mem[r_rd_ptr ^ w_pop];
        if (w_left_after_pop == 2'd0) begin
            w_head = w_sample;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            IDLE: begin
                if ((r_count != 2'd0) || w_capture) begin
                    w_state_next = BEAT0;
                end
            end
            BEAT0: begin
                if (m_axis_tready) begin
                    w_state_next = BEAT1;
                end
            end
            BEAT1: begin
                if (m_axis_tready) begin
                    w_state_next = (w_count_next != 2'd0) ? BEAT0 : IDLE;
                end
            end
            default: w_state_next = IDLE;
        endcase
    end

    always_ff @(posedge m_axis_aclk) begin
        if (!m_axis_aresetn) begin
            r_state       <= IDLE;
            r_rd_ptr      <= 1'b0;
            r_wr_ptr      <= 1'b0;
            r_count       <= 2'd0;
            r_frame_cnt   <= 32'd0;
            m_axis_tvalid <= 1'b0;
            m_axis_tdata  <= '0;
            m_axis_tlast  <= 1'b0;
            overflow      <= 1'b0;
            drop_count    <= 16'd0;
            block_flag    <= 1'b0;
        end else begin
            r_state       <= w_state_next;
            r_count       <= w_count_next;
            m_axis_tvalid <= (w_state_next != IDLE);

            if (w_pop) begin
                r_rd_ptr <= ~r_rd_ptr;
            end
            if (w_capture) begin
                r_wr_ptr <= ~r_wr_ptr;
            end

            // Output beat is registered from the head; it cannot change while
            // stalled because the head only moves on a beat1 handshake.
            if (w_state_next == BEAT0) begin
                m_axis_tdata <= w_head[31:0];
                m_axis_tlast <= 1'b0;
            end else if (w_state_next == BEAT1) begin
                m_axis_tdata <= w_head[63:32];
                m_axis_tlast <= 1'b1;
            end

            if (w_drop) begin
                overflow <= 1'b1;
                if (drop_count != 16'hFFFF) begin
                    drop_count <= drop_count + 16'd1;
                end
            end

            block_flag <= 1'b0;
            if (w_pop) begin
                if (w_frame_inc == C_RATE) begin
                    r_frame_cnt <= 32'd0;
                    block_flag  <= 1'b1;
                end else begin
                    r_frame_cnt <= w_frame_inc;
                end
            end
        end
    end

    // Storage needs no reset: entries are only read after being written.
    always_ff @(posedge m_axis_aclk) begin
        if (m_axis_aresetn && w_capture) begin
            r_mem[r_wr_ptr] <= w_sample;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_channel_stream_tx.sv
`default_nettype none
// ============================================================================
// Module      : tb_channel_stream_tx
// Description : Directed self-checking bench for channel_stream_tx, built
//               with SAMPLING_RATE = 4.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_channel_stream_tx;

    logic        clk;
    logic        aresetn;
    logic        sample_valid;
    logic [15:0] ch1, ch2, ch3, ch4;
    logic        tvalid;
    logic        tready;
    logic [31:0] tdata;
    logic        tlast;
    logic        overflow;
    logic [15:0] drop_count;
    logic        block_flag;

    int n_checks = 0;
    int n_errors = 0;

    channel_stream_tx #(
        .C_M_AXIS_TDATA_WIDTH (32),
        .SAMPLING_RATE        (4)
    ) dut (
        .m_axis_aclk    (clk),
        .m_axis_aresetn (aresetn),
        .sample_valid   (sample_valid),
        .ch1_data       (ch1),
        .ch2_data       (ch2),
        .ch3_data       (ch3),
        .ch4_data       (ch4),
        .m_axis_tvalid  (tvalid),
        .m_axis_tready  (tready),
        .m_axis_tdata   (tdata),
        .m_axis_tlast   (tlast),
        .overflow       (overflow),
        .drop_count     (drop_count),
        .block_flag     (block_flag)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_ch(input logic [15:0] a, input logic [15:0] b,
                          input logic [15:0] c, input logic [15:0] d);
        ch1 = a; ch2 = b; ch3 = c; ch4 = d;
    endtask

    task automatic send(input logic [15:0] a, input logic [15:0] b,
                        input logic [15:0] c, input logic [15:0] d);
        set_ch(a, b, c, d);
        sample_valid = 1'b1;
        step();
        sample_valid = 1'b0;
    endtask

    task automatic do_reset();
        aresetn = 1'b0;
        step();
        step();
        aresetn = 1'b1;
    endtask

    // Check the beat currently presented on the stream.
    task automatic beat(input string tag, input logic [31:0] d, input logic l);
        chk({tag, "_valid"}, {63'd0, tvalid}, 64'd1);
        chk({tag, "_data"},  {32'd0, tdata},  {32'd0, d});
        chk({tag, "_last"},  {63'd0, tlast},  {63'd0, l});
    endtask

    int hs;
    int pulses;
    logic prev_flag;

    initial begin
        aresetn      = 1'b0;
        sample_valid = 1'b0;
        tready       = 1'b1;
        set_ch(16'h0, 16'h0, 16'h0, 16'h0);
        do_reset();

        // Reset values
        chk("rst_tvalid", {63'd0, tvalid}, 64'd0);
        chk("rst_tlast",  {63'd0, tlast},  64'd0);
        chk("rst_tdata",  {32'd0, tdata},  64'd0);
        chk("rst_ovf",    {63'd0, overflow}, 64'd0);
        chk("rst_drop",   {48'd0, drop_count}, 64'd0);
        chk("rst_block",  {63'd0, block_flag}, 64'd0);

        // Single sample, ready high: latency 1, two beats, then idle
        send(16'h1111, 16'h2222, 16'h3333, 16'h4444);
        beat("single_b0", 32'h22221111, 1'b0);
        step();
        beat("single_b1", 32'h44443333, 1'b1);
        step();
        chk("single_idle", {63'd0, tvalid}, 64'd0);

        // Back-pressure on beat0 for 5 cycles
        tready = 1'b0;
        send(16'h0001, 16'h0002, 16'h0003, 16'h0004);
        for (int i = 0; i < 5; i++) begin
            beat("stall_b0", 32'h00020001, 1'b0);
            step();
        end
        tready = 1'b1;
        step();
        beat("stall_b1", 32'h00040003, 1'b1);
        step();
        chk("stall_idle", {63'd0, tvalid}, 64'd0);

        // Overflow: 3 samples while stalled, third dropped
        do_reset();
        tready = 1'b0;
        send(16'hA001, 16'hA002, 16'hA003, 16'hA004);
        send(16'hB001, 16'hB002, 16'hB003, 16'hB004);
        send(16'hC001, 16'hC002, 16'hC003, 16'hC004);
        chk("ovf_flag", {63'd0, overflow}, 64'd1);
        chk("ovf_drop", {48'd0, drop_count}, 64'd1);
        beat("ovf_a0", 32'hA002A001, 1'b0);
        tready = 1'b1;
        step();
        beat("ovf_a1", 32'hA004A003, 1'b1);
        step();
        beat("ovf_b0", 32'hB002B001, 1'b0);
        step();
        beat("ovf_b1", 32'hB004B003, 1'b1);
        step();
        chk("ovf_idle", {63'd0, tvalid}, 64'd0);
        chk("ovf_sticky", {63'd0, overflow}, 64'd1);

        // Full FIFO, sample on the beat1 handshake is accepted
        do_reset();
        tready = 1'b0;
        send(16'hA001, 16'hA002, 16'hA003, 16'hA004);
        send(16'hB001, 16'hB002, 16'hB003, 16'hB004);
        tready = 1'b1;
        step();
        beat("full_a1", 32'hA004A003, 1'b1);
        send(16'hC001, 16'hC002, 16'hC003, 16'hC004);
        chk("full_drop", {48'd0, drop_count}, 64'd0);
        chk("full_ovf",  {63'd0, overflow}, 64'd0);
        beat("full_b0", 32'hB002B001, 1'b0);
        step();
        beat("full_b1", 32'hB004B003, 1'b1);
        step();
        beat("full_c0", 32'hC002C001, 1'b0);
        step();
        beat("full_c1", 32'hC004C003, 1'b1);
        step();
        chk("full_idle", {63'd0, tvalid}, 64'd0);

        // block_flag with SAMPLING_RATE = 4 over 9 frames
        do_reset();
        tready    = 1'b1;
        hs        = 0;
        pulses    = 0;
        prev_flag = 1'b0;
        for (int c = 0; c < 30; c++) begin
            set_ch(16'(c), 16'(c + 1), 16'(c + 2), 16'(c + 3));
            sample_valid = ((c % 2) == 0) && (c < 18);
            if (tvalid && tlast && tready) hs++;
            step();
            if (block_flag) begin
                pulses++;
                chk("blk_at_hs", 64'(hs), 64'(pulses * 4));
                chk("blk_1cyc", {63'd0, prev_flag}, 64'd0);
            end
            prev_flag = block_flag;
        end
        sample_valid = 1'b0;
        chk("blk_frames", 64'(hs), 64'd9);
        chk("blk_pulses", 64'(pulses), 64'd2);

        // Reset during beat1 with one frame queued
        do_reset();
        tready = 1'b0;
        send(16'hA001, 16'hA002, 16'hA003, 16'hA004);
        send(16'hB001, 16'hB002, 16'hB003, 16'hB004);
        send(16'hC001, 16'hC002, 16'hC003, 16'hC004);
        tready = 1'b1;
        step();
        beat("mid_a1", 32'hA004A003, 1'b1);
        aresetn      = 1'b0;
        sample_valid = 1'b1;
        step();
        chk("mid_tvalid", {63'd0, tvalid}, 64'd0);
        chk("mid_ovf",    {63'd0, overflow}, 64'd0);
        chk("mid_drop",   {48'd0, drop_count}, 64'd0);
        step();
        sample_valid = 1'b0;
        aresetn      = 1'b1;
        step();
        chk("mid_quiet", {63'd0, tvalid}, 64'd0);
        send(16'hD001, 16'hD002, 16'hD003, 16'hD004);
        beat("mid_d0", 32'hD002D001, 1'b0);
        step();
        beat("mid_d1", 32'hD004D003, 1'b1);
        step();
        chk("mid_idle", {63'd0, tvalid}, 64'd0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
